// File: rtl/apple1_pkg.sv
// -----------------------------------------------------------------------------
// apple1_pkg
// Shared constants for the Apple-1 style keyboard port.
//   KBD_ADDR      - CPU address of the keyboard data register (KBD)
//   KBDCR_ADDR    - CPU address of the keyboard control/status register (KBDCR)
//   KBD_READY_BIT - bit position of the "key ready" flag in both registers
// The register window decodes on A0 only, so kbd_reg_e names the two
// registers by that single address bit.
// -----------------------------------------------------------------------------
package apple1_pkg;

    localparam logic [15:0] KBD_ADDR      = 16'hD010;
    localparam logic [15:0] KBDCR_ADDR    = 16'hD011;
    localparam int          KBD_READY_BIT = 7;

    typedef enum logic {
        REG_KBD   = 1'b0,
        REG_KBDCR = 1'b1
    } kbd_reg_e;

endpackage

// File: rtl/kbd_fifo.sv
// -----------------------------------------------------------------------------
// kbd_fifo
// Synchronous DEPTH x DATA_W FIFO with flush, used as the keyboard type-ahead.
// Push/pop arbitration lives here so the caller only presents requests.
//   sys_clock - rising-edge clock
//   reset     - synchronous, active-high; clears pointers and occupancy
//   flush     - synchronous clear, same effect as reset, wins over push/pop
//   push      - write request; accepted when not full, or full with a pop
//   push_data - value written at the tail
//   pop       - read request; accepted only when not empty
//   head      - entry at the head (valid when empty = 0)
//   count     - current occupancy, 0..DEPTH
//   empty     - occupancy is zero
//   pop_ok    - the pop request is accepted this cycle
//   dropped   - a push is refused because the FIFO is full and not popping
// -----------------------------------------------------------------------------
module kbd_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 7
) (
    input  logic                     sys_clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     pop_ok,
    output logic                     dropped
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              full;
    logic              push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // A full FIFO can still take a key if the head leaves in the same cycle.
    assign push_ok = push & (~full | pop_ok);
    assign dropped = push & full & ~pop_ok;
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge sys_clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointer wrap is plain overflow.
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; occupancy guards every read, so
    // clearing it would only add a reset fan-out to every RAM bit.
    always_ff @(posedge sys_clock) begin
        if (!reset && !flush && push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/keyboard_buffer.sv
// -----------------------------------------------------------------------------
// keyboard_buffer
// Apple-1 keyboard port (KBD / KBDCR at 0xD010-0xD011) with a type-ahead FIFO.
//   sys_clock - rising-edge system clock
//   reset     - synchronous, active-high
//   cpu_clken - CPU clock enable; qualifies every CPU access
//   key_valid - one-cycle key strobe from the key source
//   key_data  - ASCII code, bit 7 ignored
//   flush     - one-cycle request to empty the buffer, wins over push/pop
//   cs        - chip select for the register window
//   address   - A0: 0 = KBD data (read pops), 1 = KBDCR status
//   rd        - CPU read strobe
//   dout      - combinational register read data
//   count     - current FIFO occupancy
//   overflow  - one-cycle pulse after a key was dropped on a full buffer
// Build option: define KBD_UPCASE_EN to fold 'a'..'z' to 'A'..'Z' on entry.
// -----------------------------------------------------------------------------
module keyboard_buffer
    import apple1_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 7
) (
    input  logic                     sys_clock,
    input  logic                     reset,
    input  logic                     cpu_clken,
    input  logic                     key_valid,
    input  logic [7:0]               key_data,
    input  logic                     flush,
    input  logic                     cs,
    input  logic                     address,
    input  logic                     rd,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    kbd_reg_e          reg_sel;
    logic [6:0]        key_code;
    logic              pop_req;
    logic [DATA_W-1:0] head;
    logic              empty;
    logic              pop_ok;
    logic              dropped;
    logic [DATA_W-1:0] last_byte;
    logic [6:0]        head7;
    logic [6:0]        last7;

    assign reg_sel = kbd_reg_e'(address);
    assign pop_req = cpu_clken & cs & rd & (reg_sel == REG_KBD);

    // NOTE: always_comb assigns a default first so no path leaves a variable
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        key_code = key_data[6:0];
`ifdef KBD_UPCASE_EN
        if (key_code >= 7'h61 && key_code <= 7'h7A) begin
            key_code = key_code - 7'h20;
        end
`endif
    end

    kbd_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .sys_clock (sys_clock),
        .reset     (reset),
        .flush     (flush),
        .push      (key_valid),
        .push_data (DATA_W'(key_code)),
        .pop       (pop_req),
        .head      (head),
        .count     (count),
        .empty     (empty),
        .pop_ok    (pop_ok),
        .dropped   (dropped)
    );

    // KBD keeps showing the last consumed key (ready bit clear) once the
    // buffer drains, as the original single-latch Apple-1 port did.
    always_ff @(posedge sys_clock) begin
        if (reset || flush) begin
            last_byte <= '0;
            overflow  <= 1'b0;
        end else begin
            if (pop_ok) last_byte <= head;
            overflow <= dropped;
        end
    end

    assign head7 = 7'(head);
    assign last7 = 7'(last_byte);

    always_comb begin
        dout = 8'h00;
        case (reg_sel)
            REG_KBD:   dout = empty ? {1'b0, last7} : {1'b1, head7};
            REG_KBDCR: dout[KBD_READY_BIT] = ~empty;
            default:   dout = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_keyboard_buffer.sv
// -----------------------------------------------------------------------------
// tb_keyboard_buffer
// Directed bench for keyboard_buffer (DEPTH = 16). Inputs change 1 ns after
// the rising edge; outputs are sampled there too, away from the edge.
// Expected values follow KBD_UPCASE_EN when the bench is built with it.
// -----------------------------------------------------------------------------
module tb_keyboard_buffer;

    logic       sys_clock = 1'b0;
    logic       reset;
    logic       cpu_clken;
    logic       key_valid;
    logic [7:0] key_data;
    logic       flush;
    logic       cs;
    logic       address;
    logic       rd;
    logic [7:0] dout;
    logic [4:0] count;
    logic       overflow;

    int vectors     = 0;
    int miscompares = 0;

    always #5 sys_clock = ~sys_clock;

    keyboard_buffer #(.DEPTH(16), .DATA_W(7)) dut (
        .sys_clock (sys_clock),
        .reset     (reset),
        .cpu_clken (cpu_clken),
        .key_valid (key_valid),
        .key_data  (key_data),
        .flush     (flush),
        .cs        (cs),
        .address   (address),
        .rd        (rd),
        .dout      (dout),
        .count     (count),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clock);
        #1;
    endtask

    task automatic push(input logic [7:0] k);
        key_valid = 1'b1;
        key_data  = k;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic cpu_read(input logic a, input logic [7:0] exp, input string tag);
        cpu_clken = 1'b1;
        cs        = 1'b1;
        rd        = 1'b1;
        address   = a;
        #1;
        check(tag, 16'(dout), 16'(exp));
        tick();
        cpu_clken = 1'b0;
        cs        = 1'b0;
        rd        = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with a key strobe and a pop pending: both must be ignored.
        reset = 1'b1; key_valid = 1'b1; key_data = 8'h41; flush = 1'b0;
        cpu_clken = 1'b1; cs = 1'b1; rd = 1'b1; address = 1'b0;
        tick();
        tick();
        reset = 1'b0; key_valid = 1'b0; cpu_clken = 1'b0; cs = 1'b0; rd = 1'b0;
        check("reset_count", 16'(count), 16'd0);
        check("reset_overflow", 16'(overflow), 16'd0);
        cpu_read(1'b1, 8'h00, "reset_kbdcr");
        cpu_read(1'b0, 8'h00, "reset_kbd");
        check("reset_count_after_reads", 16'(count), 16'd0);

        // 'H','I' (second with bit 7 set, which must be ignored).
        push(8'h48);
        push(8'hC9);
        check("hi_count", 16'(count), 16'd2);
        cpu_read(1'b1, 8'h80, "hi_kbdcr_ready");
        check("hi_kbdcr_no_pop", 16'(count), 16'd2);
        cpu_read(1'b0, 8'hC8, "hi_read_h");
        cpu_read(1'b0, 8'hC9, "hi_read_i");
        cpu_read(1'b1, 8'h00, "hi_kbdcr_empty");
        cpu_read(1'b0, 8'h49, "hi_kbd_last");

        // Reads without cpu_clken, or with rd low, have no side effect.
        push(8'h31);
        cs = 1'b1; rd = 1'b1; address = 1'b0; cpu_clken = 1'b0;
        tick();
        check("no_clken_no_pop", 16'(count), 16'd1);
        cpu_clken = 1'b1; rd = 1'b0;
        tick();
        cpu_clken = 1'b0; cs = 1'b0;
        check("no_rd_no_pop", 16'(count), 16'd1);
        cpu_read(1'b0, 8'hB1, "clken_read");

        // 17 keys into 16 entries: only the 17th drops, with one overflow pulse.
        for (int i = 0; i < 17; i++) begin
            push(8'h41 + 8'(i));
            check($sformatf("fill_overflow_%0d", i), 16'(overflow), (i == 16) ? 16'd1 : 16'd0);
        end
        check("full_count", 16'(count), 16'd16);

        // Full: push 'Z' and pop together; both happen, no overflow.
        key_valid = 1'b1; key_data = 8'h5A;
        cpu_clken = 1'b1; cs = 1'b1; rd = 1'b1; address = 1'b0;
        #1;
        check("full_pushpop_head", 16'(dout), 16'h00C1);
        tick();
        key_valid = 1'b0; cpu_clken = 1'b0; cs = 1'b0; rd = 1'b0;
        check("full_pushpop_overflow", 16'(overflow), 16'd0);
        check("full_pushpop_count", 16'(count), 16'd16);
        for (int i = 0; i < 15; i++) begin
            cpu_read(1'b0, 8'hC2 + 8'(i), $sformatf("drain_%0d", i));
        end
        cpu_read(1'b0, 8'hDA, "drain_last_z");
        check("drain_count", 16'(count), 16'd0);
        cpu_read(1'b0, 8'h5A, "drain_kbd_last");

        // Empty: push and pop together; pop ignored, push accepted.
        key_valid = 1'b1; key_data = 8'h33;
        cpu_clken = 1'b1; cs = 1'b1; rd = 1'b1; address = 1'b0;
        #1;
        check("empty_pushpop_dout", 16'(dout), 16'h005A);
        tick();
        key_valid = 1'b0; cpu_clken = 1'b0; cs = 1'b0; rd = 1'b0;
        check("empty_pushpop_count", 16'(count), 16'd1);
        cpu_read(1'b0, 8'hB3, "empty_pushpop_read");

        // Flush with a key strobe and a pop: everything cleared, key discarded.
        push(8'h31);
        push(8'h32);
        push(8'h33);
        check("preflush_count", 16'(count), 16'd3);
        flush = 1'b1; key_valid = 1'b1; key_data = 8'h34;
        cpu_clken = 1'b1; cs = 1'b1; rd = 1'b1; address = 1'b0;
        tick();
        flush = 1'b0; key_valid = 1'b0; cpu_clken = 1'b0; cs = 1'b0; rd = 1'b0;
        check("flush_count", 16'(count), 16'd0);
        cpu_read(1'b0, 8'h00, "flush_kbd");
        cpu_read(1'b1, 8'h00, "flush_kbdcr");
        push(8'h35);
        cpu_read(1'b0, 8'hB5, "postflush_read");

        // Case folding.
        push(8'h61);
        push(8'h7B);
        push(8'h7A);
        push(8'h60);
`ifdef KBD_UPCASE_EN
        cpu_read(1'b0, 8'hC1, "fold_a");
        cpu_read(1'b0, 8'hFB, "fold_brace");
        cpu_read(1'b0, 8'hDA, "fold_z");
`else
        cpu_read(1'b0, 8'hE1, "fold_a");
        cpu_read(1'b0, 8'hFB, "fold_brace");
        cpu_read(1'b0, 8'hFA, "fold_z");
`endif
        cpu_read(1'b0, 8'hE0, "fold_backtick");

        // Reset mid-stream discards keys and ignores the strobe in that cycle.
        push(8'h41);
        push(8'h42);
        reset = 1'b1; key_valid = 1'b1; key_data = 8'h43;
        tick();
        reset = 1'b0; key_valid = 1'b0;
        check("midreset_count", 16'(count), 16'd0);
        cpu_read(1'b0, 8'h00, "midreset_kbd");
        push(8'h44);
        check("midreset_push_count", 16'(count), 16'd1);
        cpu_read(1'b0, 8'hC4, "midreset_first_key");
        cpu_read(1'b0, 8'h44, "midreset_last");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/keyboard_buffer.md
KEYBOARD_BUFFER -- requirements
Module: keyboard_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning FIFO entries (power of two, 2..64).
REQ-002 The block SHALL have parameter DATA_W, default 7, meaning stored ASCII width.
REQ-003 The block SHALL have port sys_clock  in  1  single system clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port reset  in  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port cpu_clken  in  1  CPU clock enable; qualifies every CPU-side access.
REQ-006 The block SHALL have port key_valid  in  1  one-cycle strobe from the key source (PS/2 decoder or serial).
REQ-007 The block SHALL have port key_data  in  8  ASCII code; bit 7 is ignored.
REQ-008 The block SHALL have port flush  in  1  one-cycle request to empty the buffer (reset/clear hot-key).
REQ-009 The block SHALL have port cs  in  1  chip select for the 0xD010-0xD011 window.
REQ-010 The block SHALL have port address  in  1  CPU A0; 0=KBD data, 1=KBDCR status.
REQ-011 The block SHALL have port rd  in  1  CPU read (R_W_n high).
REQ-012 The block SHALL have port dout  out  8  combinational register read data.
REQ-013 The block SHALL have port count  out  log2(DEPTH)+1  current occupancy.
REQ-014 The block SHALL have port overflow  out  1  one-cycle pulse when a key is dropped.

Function
REQ-015 Push: key_valid=1 with occupancy<DEPTH SHALL write key_data[6:0] at the tail; the entry is visible in dout/count the next cycle.
REQ-016 Pop: cpu_clken & cs & rd & ~address SHALL consume the head entry when non-empty; a pop on empty SHALL be ignored.
REQ-017 Read at address=0 SHALL return {1, head} when non-empty, else {0, last popped byte} (0x00 after reset).
REQ-018 Read at address=1 SHALL return {~empty, 7'b0} and SHALL NOT pop.
REQ-019 Read without cpu_clken, or with wr (rd=0), SHALL have no side effect; writes are otherwise ignored.
REQ-020 Full, push without simultaneous pop: the key SHALL be dropped, overflow pulses for one cycle, and contents are unchanged.
REQ-021 Full, simultaneous push and pop: both SHALL occur; count stays DEPTH; no overflow.
REQ-022 Empty, simultaneous push and pop: the pop is ignored, the push is accepted, and count becomes 1.
REQ-023 Pointers SHALL wrap modulo DEPTH; count SHALL be exact at 0 and DEPTH.
REQ-024 flush SHALL have priority over push and pop in the same cycle: count->0, pointers->0, last popped byte->0x00, and the key is discarded.
REQ-025 Order SHALL be strict FIFO; no entry is lost or duplicated except as stated in REQ-020 and REQ-024.

Reset
REQ-026 While reset=1 on a clock edge, the block SHALL force count=0, pointers=0, last popped byte=0x00, and overflow=0; dout then reads 0x00 (addr 0) or 0x00 (addr 1).
REQ-027 The block SHALL ignore key_valid and pops in any cycle where reset=1; storage RAM contents need not be cleared.
REQ-028 Reset asserted mid-stream SHALL discard all buffered keys; the first key after release SHALL be stored at index 0.

Configuration
REQ-029 The block SHALL provide macro KBD_UPCASE_EN: when defined, pushed codes 0x61-0x7A are stored minus 0x20 (uppercase), and all other codes are unchanged.
REQ-030 When KBD_UPCASE_EN is undefined, the block SHALL store key_data[6:0] verbatim.

Structure
REQ-031 Package apple1_pkg SHALL hold the constants KBD_ADDR=16'hD010, KBDCR_ADDR=16'hD011, and KBD_READY_BIT=7.
REQ-032 Storage and pointers SHALL be in the one sub-module kbd_fifo (sync FIFO, DEPTH x DATA_W, with flush); register decode/mux and case folding SHALL be in keyboard_buffer.

Verification
REQ-033 A bench SHALL cover this scenario: after reset, read 0xD011 -> 0x00; read 0xD010 -> 0x00; count=0.
REQ-034 A bench SHALL cover this scenario: push 'H'(0x48), 'I'(0x49) -> KBDCR=0x80; read KBD -> 0xC8, then 0xC9; then KBDCR=0x00 and KBD=0x49.
REQ-035 A bench SHALL cover this scenario: push 17 keys 0x41.. with DEPTH=16 -> one overflow pulse on the 17th; 16 reads return 0xC1..0xD0.
REQ-036 A bench SHALL cover this scenario: full buffer, push 0x5A and pop on the same cycle -> pop returns the oldest, no overflow, count=16, last read=0xDA.
REQ-037 A bench SHALL cover this scenario: 3 keys buffered, flush together with key_valid -> count=0, KBD=0x00, the new key is absent.
REQ-038 A bench SHALL cover this scenario: with KBD_UPCASE_EN, push 0x61 -> read 0xC1; push 0x7B -> read 0xFB; without the macro, push 0x61 -> read 0xE1.
